four_color_top: RTL and testbench

- Hardware four-colour map solver: depth-first backtracking search assigning colours 0..3 to N regions so that no two adjacent regions share a colour.
- Map adjacency is fixed at elaboration by a parameter. The search starts automatically when reset is released.
- 4-bit `in` selects a region whose colour is shown on a readout port.
- Top-level block of the four-colour design; a display wrapper, if any, sits outside it.

---
 rtl/four_color_top_if.sv | 27 ++
 rtl/four_color_top.sv | 80 ++++++++
 tb/tb_four_color_top.sv | 109 ++++++++++
 3 files changed

// File: rtl/four_color_top_if.sv
// four_color_top_if: readout select and status/colour bundle of the four-colour solver (FOUR_COLOR_STEP_CNT_EN adds step_cnt)
interface four_color_top_if #(parameter int N_REGIONS = 4);
    logic [3:0]             in;
    logic [2*N_REGIONS-1:0] colors;
    logic [1:0]             sel_color;
    logic                   sel_valid;
    logic                   busy;
    logic                   done;
    logic                   fail;
`ifdef FOUR_COLOR_STEP_CNT_EN
    logic [15:0]            step_cnt;
`endif
    modport master (
        output in,
`ifdef FOUR_COLOR_STEP_CNT_EN
        input  step_cnt,
`endif
        input  colors, sel_color, sel_valid, busy, done, fail
    );
    modport slave (
        input  in,
`ifdef FOUR_COLOR_STEP_CNT_EN
        output step_cnt,
`endif
        output colors, sel_color, sel_valid, busy, done, fail
    );
endinterface

// File: rtl/four_color_top.sv
// four_color_top: backtracking four-colour map solver, one candidate per cycle; FOUR_COLOR_STEP_CNT_EN adds a saturating search-step counter
module four_color_top #(
    parameter int N_REGIONS = 4,
    parameter logic [N_REGIONS*N_REGIONS-1:0] ADJ = {(N_REGIONS*N_REGIONS){1'b1}}
) (
    input logic             clk,
    input logic             rst,
    four_color_top_if.slave bus
);
    localparam int W = 2 * N_REGIONS;
    typedef enum logic [1:0] {SEARCH, BACK, DONE, FAIL} state_t;
    state_t                 state_q, state_d;
    logic [3:0]             k_q, k_d;
    logic [W-1:0]           col_q, col_d;
    logic [N_REGIONS*N_REGIONS-1:0] pair_hit;
    logic                   conflict;
    logic [1:0]             cur, prev;
    for (genvar i = 0; i < N_REGIONS; i++) begin : g_i
        for (genvar j = 0; j < N_REGIONS; j++) begin : g_j
            assign pair_hit[i*N_REGIONS+j] = (j < i) && ADJ[i*N_REGIONS+j] && (k_q == 4'(i)) && (col_q[2*i+:2] == col_q[2*j+:2]);
        end
    end
    assign conflict = |pair_hit;
    assign cur      = 2'(col_q >> {k_q, 1'b0});
    assign prev     = 2'(col_q >> {k_q - 4'd1, 1'b0});
    // search step: advance, bump the current colour, or backtrack to the previous region
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        col_d   = col_q;
        case (state_q)
            SEARCH:
                if (!conflict) begin
                    if (k_q == 4'(N_REGIONS - 1)) state_d = DONE;
                    else begin
                        k_d   = k_q + 4'd1;
                        col_d = col_q & ~(W'(3) << {k_q + 4'd1, 1'b0});
                    end
                end else if (cur != 2'd3) col_d = col_q + (W'(1) << {k_q, 1'b0});
                else state_d = BACK;
            BACK:
                if (k_q == 4'd0) state_d = FAIL;
                else begin
                    k_d = k_q - 4'd1;
                    if (prev != 2'd3) begin
                        col_d   = col_q + (W'(1) << {k_q - 4'd1, 1'b0});
                        state_d = SEARCH;
                    end
                end
            default: ;
        endcase
    end
    // search state register; DONE/FAIL hold everything until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEARCH;
            k_q     <= 4'd0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            col_q   <= col_d;
        end
    end
    assign bus.colors    = col_q;
    assign bus.busy      = (state_q == SEARCH) || (state_q == BACK);
    assign bus.done      = state_q == DONE;
    assign bus.fail      = state_q == FAIL;
    assign bus.sel_valid = int'(bus.in) < N_REGIONS;
    assign bus.sel_color = bus.sel_valid ? 2'(col_q >> {bus.in, 1'b0}) : 2'd0;
`ifdef FOUR_COLOR_STEP_CNT_EN
    logic [15:0] cnt_q;
    // count search/backtrack cycles, saturating, frozen once the search ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 16'd0;
        else if (bus.busy && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign bus.step_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_four_color_top.sv
// tb_four_color_top: directed bench over K4, K3, a 4-node path and K5 solver instances
module tb_four_color_top;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    typedef struct { string tag; logic [31:0] exp; } sb_t;
    sb_t  sb[$];
    four_color_top_if #(.N_REGIONS(4)) if4 ();
    four_color_top_if #(.N_REGIONS(3)) if3 ();
    four_color_top_if #(.N_REGIONS(4)) ifp ();
    four_color_top_if #(.N_REGIONS(5)) if5 ();
    four_color_top #(.N_REGIONS(4), .ADJ(16'h7BDE))        u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    four_color_top #(.N_REGIONS(3), .ADJ(9'b011101110))    u3 (.clk(clk), .rst(rst), .bus(if3.slave));
    four_color_top #(.N_REGIONS(4), .ADJ(16'h4A52))        up (.clk(clk), .rst(rst), .bus(ifp.slave));
    four_color_top #(.N_REGIONS(5), .ADJ(25'h1FFFFFF))     u5 (.clk(clk), .rst(rst), .bus(if5.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic sb_check(input string tag, input logic [31:0] got);
        sb_t s;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        s = sb.pop_front();
        check({tag, "/", s.tag}, got, s.exp);
    endtask
    initial begin
        int n5 = 0;
        int n5b = 0;
        logic [9:0] fail_cols;
        rst = 1'b0;
        if4.in = 4'd0; if3.in = 4'd0; ifp.in = 4'd0; if5.in = 4'd0;
        #12;
        check("rst_k4_colors", 32'(if4.colors), 32'd0);
        check("rst_k5_colors", 32'(if5.colors), 32'd0);
        check("rst_k4_done", 32'(if4.done), 32'd0);
        check("rst_k4_fail", 32'(if4.fail), 32'd0);
        check("rst_k5_fail", 32'(if5.fail), 32'd0);
        @(negedge clk) rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            check($sformatf("k4_done_e%0d", e), 32'(if4.done), 32'(e == 10));
            check($sformatf("k3_done_e%0d", e), 32'(if3.done), 32'(e >= 6));
            check($sformatf("path_done_e%0d", e), 32'(ifp.done), 32'(e >= 6));
        end
        sb.push_back('{"k4_colors", 32'hE4});
        sb.push_back('{"k3_colors", 32'h24});
        sb.push_back('{"path_colors", 32'h44});
        sb_check("res", 32'(if4.colors));
        sb_check("res", 32'(if3.colors));
        sb_check("res", 32'(ifp.colors));
        check("k4_busy", 32'(if4.busy), 32'd0);
        check("k4_fail", 32'(if4.fail), 32'd0);
        check("k3_busy", 32'(if3.busy), 32'd0);
`ifdef FOUR_COLOR_STEP_CNT_EN
        check("k4_step_cnt", 32'(if4.step_cnt), 32'd10);
        check("k3_step_cnt", 32'(if3.step_cnt), 32'd6);
        check("path_step_cnt", 32'(ifp.step_cnt), 32'd6);
`endif
        for (int e = 11; e <= 5000 && n5 == 0; e++) begin
            @(posedge clk); #1;
            if (if5.fail) n5 = e;
        end
        check("k5_fail_within_budget", 32'(n5 != 0), 32'd1);
        fail_cols = if5.colors;
        repeat (1000) @(posedge clk);
        #1;
        check("k5_fail_latched", 32'(if5.fail), 32'd1);
        check("k5_busy", 32'(if5.busy), 32'd0);
        check("k5_done", 32'(if5.done), 32'd0);
        check("k5_colors_frozen", 32'(if5.colors), 32'(fail_cols));
        check("k4_done_latched", 32'(if4.done), 32'd1);
        check("k4_colors_frozen", 32'(if4.colors), 32'hE4);
        for (int i = 0; i < 16; i++) begin
            if4.in = 4'(i);
            sb.push_back('{$sformatf("sel_in%0d", i), (i < 4) ? 32'(4 + i) : 32'd0});
            #1;
            sb_check("readout", 32'({if4.sel_valid, if4.sel_color}));
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (7) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_k5_colors", 32'(if5.colors), 32'd0);
        check("midrst_k5_done", 32'(if5.done), 32'd0);
        check("midrst_k5_fail", 32'(if5.fail), 32'd0);
        check("midrst_k4_done", 32'(if4.done), 32'd0);
        @(negedge clk) rst = 1'b1;
        for (int e = 1; e <= 5000 && n5b == 0; e++) begin
            @(posedge clk); #1;
            if (e == 9 || e == 10) check($sformatf("rerun_k4_done_e%0d", e), 32'(if4.done), 32'(e == 10));
            if (if5.fail) n5b = e;
        end
        check("rerun_k5_fail_time", 32'(n5b), 32'(n5));
        check("rerun_k5_colors", 32'(if5.colors), 32'(fail_cols));
        check("rerun_k4_colors", 32'(if4.colors), 32'hE4);
        check("rerun_k5_not_done", 32'(if5.done), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
